// File: rtl/mod_148_4_4_clk_timer_pkg.sv
// Shared definitions for the clocked PLCA/beacon timer set: state encodings,
// default cycle counts and a length-legality helper used at elaboration.
package mod_148_4_4_clk_timer_pkg;

   typedef enum logic [1:0] {
      TMR_IDLE    = 2'b00,
      TMR_RUN     = 2'b01,
      TMR_EXPIRED = 2'b10
   } tmr_state_e;

   // Default timer lengths in clocks at a 40 ns clock period.
   localparam int DEF_CLK_PERIOD_NS     = 40;
   localparam int DEF_CNT_W             = 9;
   localparam int DEF_BEACON_CYC        = 50;   // 2000 ns
   localparam int DEF_BEACON_DET_CYC    = 55;   // 2200 ns
   localparam int DEF_INVALID_BEACON_CYC = 100; // 4000 ns
   localparam int DEF_BURST_CYC         = 320;  // 12800 ns
   localparam int DEF_TO_CYC            = 80;   // 3200 ns

   // A timer length must be at least one clock and fit the counter (N-1 loaded).
   function automatic bit cyc_len_ok(input int n, input int cnt_w);
      return (n >= 1) && (n <= ((1 << cnt_w) - 1));
   endfunction

endpackage

// File: rtl/mod_148_4_4_clk_timer_if.sv
// Start/stop request and done/not_done status bundle for the five timers.
// master: control state machines; slave: the timer block.
interface mod_148_4_4_clk_timer_if;
   import mod_148_4_4_clk_timer_pkg::*;

   logic start_beacon_timer;
   logic start_beacon_det_timer;
   logic start_invalid_beacon_timer;
   logic start_burst_timer;
   logic start_to_timer;

   logic stop_beacon_timer;
   logic stop_beacon_det_timer;
   logic stop_invalid_beacon_timer;
   logic stop_burst_timer;
   logic stop_to_timer;

   logic beacon_timer_done;
   logic beacon_det_timer_done;
   logic invalid_beacon_timer_done;
   logic burst_timer_done;
   logic to_timer_done;

   logic beacon_timer_not_done;
   logic beacon_det_timer_not_done;
   logic invalid_beacon_timer_not_done;
   logic burst_timer_not_done;
   logic to_timer_not_done;

   modport master (
      output start_beacon_timer, start_beacon_det_timer, start_invalid_beacon_timer,
             start_burst_timer, start_to_timer,
             stop_beacon_timer, stop_beacon_det_timer, stop_invalid_beacon_timer,
             stop_burst_timer, stop_to_timer,
      input  beacon_timer_done, beacon_det_timer_done, invalid_beacon_timer_done,
             burst_timer_done, to_timer_done,
             beacon_timer_not_done, beacon_det_timer_not_done, invalid_beacon_timer_not_done,
             burst_timer_not_done, to_timer_not_done
   );

   modport slave (
      input  start_beacon_timer, start_beacon_det_timer, start_invalid_beacon_timer,
             start_burst_timer, start_to_timer,
             stop_beacon_timer, stop_beacon_det_timer, stop_invalid_beacon_timer,
             stop_burst_timer, stop_to_timer,
      output beacon_timer_done, beacon_det_timer_done, invalid_beacon_timer_done,
             burst_timer_done, to_timer_done,
             beacon_timer_not_done, beacon_det_timer_not_done, invalid_beacon_timer_not_done,
             burst_timer_not_done, to_timer_not_done
   );

endinterface

// File: rtl/mod_148_4_4_clk_timer_unit.sv
// Single N-clock timer: IDLE / RUN / EXPIRED with registered done/not_done.
// Start (or restart) wins over stop and over a same-edge expiry.
module mod_148_timer_unit
   import mod_148_4_4_clk_timer_pkg::*;
#(
   parameter int N     = DEF_BEACON_CYC,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic stop,
   output logic done,
   output logic not_done
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(N - 1);

   generate
      if (!cyc_len_ok(N, CNT_W)) begin : g_bad_len
         $error("mod_148_timer_unit: N=%0d is not legal for CNT_W=%0d", N, CNT_W);
      end
   endgenerate

   tmr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             not_done_q, not_done_d;

   // Next state, counter and status; counter holds at zero, never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start) begin
         state_d = TMR_RUN;
         cnt_d   = RELOAD;
      end else if (stop) begin
         state_d = TMR_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            TMR_RUN: begin
               if (cnt_q == '0) begin
                  state_d = TMR_EXPIRED;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            TMR_EXPIRED: state_d = TMR_EXPIRED;
            TMR_IDLE:    state_d = TMR_IDLE;
            default: begin
               state_d = TMR_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      done_d     = (state_d == TMR_EXPIRED);
      not_done_d = (state_d == TMR_RUN);
   end

   // State, counter and status registers; reset aborts any run at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= TMR_IDLE;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         not_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         not_done_q <= not_done_d;
      end
   end

   assign done     = done_q;
   assign not_done = not_done_q;

endmodule

// File: rtl/mod_148_4_4_clk_timer.sv
// Clocked PLCA/beacon timer set: five independent timer units wired to the
// request/status interface, plus elaboration-time parameter checks.
module mod_148_4_4_clk_timer
   import mod_148_4_4_clk_timer_pkg::*;
#(
   parameter int CLK_PERIOD_NS      = DEF_CLK_PERIOD_NS,
   parameter int CNT_W              = DEF_CNT_W,
   parameter int BEACON_CYC         = DEF_BEACON_CYC,
   parameter int BEACON_DET_CYC     = DEF_BEACON_DET_CYC,
   parameter int INVALID_BEACON_CYC = DEF_INVALID_BEACON_CYC,
   parameter int BURST_CYC          = DEF_BURST_CYC,
   parameter int TO_CYC             = DEF_TO_CYC
) (
   input logic                     clk,
   input logic                     reset_n,
   mod_148_4_4_clk_timer_if.slave  tif
);

   generate
      if (CLK_PERIOD_NS <= 0) begin : g_bad_period
         $error("mod_148_4_4_clk_timer: CLK_PERIOD_NS must be positive");
      end
      if (!cyc_len_ok(BEACON_CYC, CNT_W) || !cyc_len_ok(BEACON_DET_CYC, CNT_W) ||
          !cyc_len_ok(INVALID_BEACON_CYC, CNT_W) || !cyc_len_ok(BURST_CYC, CNT_W) ||
          !cyc_len_ok(TO_CYC, CNT_W)) begin : g_bad_len
         $error("mod_148_4_4_clk_timer: a timer length is 0 or exceeds 2^CNT_W-1");
      end
   endgenerate

   mod_148_timer_unit #(.N(BEACON_CYC), .CNT_W(CNT_W)) u_beacon (
      .clk(clk), .reset_n(reset_n),
      .start(tif.start_beacon_timer), .stop(tif.stop_beacon_timer),
      .done(tif.beacon_timer_done), .not_done(tif.beacon_timer_not_done)
   );

   mod_148_timer_unit #(.N(BEACON_DET_CYC), .CNT_W(CNT_W)) u_beacon_det (
      .clk(clk), .reset_n(reset_n),
      .start(tif.start_beacon_det_timer), .stop(tif.stop_beacon_det_timer),
      .done(tif.beacon_det_timer_done), .not_done(tif.beacon_det_timer_not_done)
   );

   mod_148_timer_unit #(.N(INVALID_BEACON_CYC), .CNT_W(CNT_W)) u_invalid_beacon (
      .clk(clk), .reset_n(reset_n),
      .start(tif.start_invalid_beacon_timer), .stop(tif.stop_invalid_beacon_timer),
      .done(tif.invalid_beacon_timer_done), .not_done(tif.invalid_beacon_timer_not_done)
   );

   mod_148_timer_unit #(.N(BURST_CYC), .CNT_W(CNT_W)) u_burst (
      .clk(clk), .reset_n(reset_n),
      .start(tif.start_burst_timer), .stop(tif.stop_burst_timer),
      .done(tif.burst_timer_done), .not_done(tif.burst_timer_not_done)
   );

   mod_148_timer_unit #(.N(TO_CYC), .CNT_W(CNT_W)) u_to (
      .clk(clk), .reset_n(reset_n),
      .start(tif.start_to_timer), .stop(tif.stop_to_timer),
      .done(tif.to_timer_done), .not_done(tif.to_timer_not_done)
   );

endmodule

// File: tb/tb_mod_148_4_4_clk_timer.sv
// Bench for the clocked timer set. Expected done/not_done vectors are queued
// per clock edge by the stimulus; a negedge monitor pops and compares them.
// Bit order of the 5-bit vectors: 0 beacon, 1 beacon_det, 2 invalid_beacon,
// 3 burst, 4 to.
module tb_mod_148_4_4_clk_timer;

   logic clk = 1'b0;
   logic reset_n;

   mod_148_4_4_clk_timer_if tif();

   mod_148_4_4_clk_timer dut (
      .clk(clk),
      .reset_n(reset_n),
      .tif(tif)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far; edge k is observed at the following negedge.
   int unsigned ecount = 0;
   always @(posedge clk) ecount <= ecount + 1;

   typedef struct {
      int unsigned edge_n;
      logic [4:0]  done;
      logic [4:0]  nd;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [4:0] act_done, act_nd;
   assign act_done = {tif.to_timer_done, tif.burst_timer_done, tif.invalid_beacon_timer_done,
                      tif.beacon_det_timer_done, tif.beacon_timer_done};
   assign act_nd   = {tif.to_timer_not_done, tif.burst_timer_not_done,
                      tif.invalid_beacon_timer_not_done, tif.beacon_det_timer_not_done,
                      tif.beacon_timer_not_done};

   // Monitor: compare every queued expectation that belongs to the current edge.
   always @(negedge clk) begin
      while (sb_q.size() != 0 && sb_q[0].edge_n <= ecount) begin
         cur = sb_q.pop_front();
         n_checks++;
         if (cur.edge_n != ecount)
            $display("FAIL %s edge %0d: expectation missed (monitor at edge %0d)",
                     cur.tag, cur.edge_n, ecount);
         else if (act_done !== cur.done || act_nd !== cur.nd)
            $display("FAIL %s edge %0d: done=%b not_done=%b, required done=%b not_done=%b",
                     cur.tag, cur.edge_n, act_done, act_nd, cur.done, cur.nd);
         else
            n_pass++;
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_until(input int unsigned e);
      while (ecount < e) tick();
   endtask

   task automatic set_req(input logic [4:0] st, input logic [4:0] sp);
      tif.start_beacon_timer         = st[0];
      tif.start_beacon_det_timer     = st[1];
      tif.start_invalid_beacon_timer = st[2];
      tif.start_burst_timer          = st[3];
      tif.start_to_timer             = st[4];
      tif.stop_beacon_timer          = sp[0];
      tif.stop_beacon_det_timer      = sp[1];
      tif.stop_invalid_beacon_timer  = sp[2];
      tif.stop_burst_timer           = sp[3];
      tif.stop_to_timer              = sp[4];
   endtask

   // One-cycle request, sampled at the next rising edge (edge ecount+1).
   task automatic pulse(input logic [4:0] st, input logic [4:0] sp);
      set_req(st, sp);
      tick();
      set_req(5'b0, 5'b0);
   endtask

   task automatic push(input int unsigned e, input logic [4:0] d, input logic [4:0] n,
                       input string tag);
      exp_t x;
      x.edge_n = e;
      x.done   = d;
      x.nd     = n;
      x.tag    = tag;
      sb_q.push_back(x);
   endtask

   // Cancel everything; every timer must read IDLE from the stop edge onward.
   task automatic stop_all();
      int unsigned e;
      e = ecount;
      push(e + 1, 5'b0, 5'b0, "stop_all");
      push(e + 2, 5'b0, 5'b0, "stop_all_hold");
      pulse(5'b0, 5'h1f);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending",
               sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned b;
      logic [4:0]  d, n;

      reset_n = 1'b0;
      set_req(5'b0, 5'b0);
      tick();

      // Reset state.
      b = ecount + 1;
      for (int t = 0; t < 3; t++) push(b + t, 5'b0, 5'b0, "reset_state");
      wait_until(b + 2);
      reset_n = 1'b1;

      // No starts for 500 clocks: everything stays quiet.
      b = ecount + 1;
      for (int t = 0; t < 500; t++) push(b + t, 5'b0, 5'b0, "idle");
      wait_until(b + 499);

      // beacon_timer started at edge 10: running 10..59, done from 60, held 200 clocks.
      b = ecount + 1;
      for (int t = 0; t <= 260; t++) begin
         d = 5'b0; n = 5'b0;
         d[0] = (t >= 60);
         n[0] = (t >= 10) && (t <= 59);
         push(b + t, d, n, "beacon");
      end
      wait_until(b + 9);
      pulse(5'b00001, 5'b0);
      wait_until(b + 260);
      stop_all();

      // burst_timer started at 0, restarted at 300: running through 619, done at 620.
      b = ecount + 1;
      for (int t = 0; t <= 630; t++) begin
         d = 5'b0; n = 5'b0;
         d[3] = (t >= 620);
         n[3] = (t <= 619);
         push(b + t, d, n, "burst_restart");
      end
      pulse(5'b01000, 5'b0);
      wait_until(b + 299);
      pulse(5'b01000, 5'b0);
      wait_until(b + 630);
      stop_all();

      // to_timer started at 0; stop raised after edge 40 so it is taken at edge 41.
      b = ecount + 1;
      for (int t = 0; t <= 200; t++) begin
         d = 5'b0; n = 5'b0;
         n[4] = (t <= 40);
         push(b + t, d, n, "to_stop");
      end
      pulse(5'b10000, 5'b0);
      wait_until(b + 40);
      pulse(5'b0, 5'b10000);
      wait_until(b + 200);
      stop_all();

      // invalid_beacon_timer: start and stop together at edge 5, start wins.
      b = ecount + 1;
      for (int t = 0; t <= 120; t++) begin
         d = 5'b0; n = 5'b0;
         d[2] = (t >= 105);
         n[2] = (t >= 5) && (t <= 104);
         push(b + t, d, n, "inv_start_stop");
      end
      wait_until(b + 4);
      pulse(5'b00100, 5'b00100);
      wait_until(b + 120);
      stop_all();

      // beacon_det_timer restarted on its expiry edge (55): no done until 110.
      b = ecount + 1;
      for (int t = 0; t <= 115; t++) begin
         d = 5'b0; n = 5'b0;
         d[1] = (t >= 110);
         n[1] = (t <= 109);
         push(b + t, d, n, "det_restart_at_expiry");
      end
      pulse(5'b00010, 5'b0);
      wait_until(b + 54);
      pulse(5'b00010, 5'b0);
      wait_until(b + 115);
      stop_all();

      // All five started at 0, reset asserted 3 ns after edge 30: all zero, no late done.
      b = ecount + 1;
      for (int t = 0; t <= 29; t++) push(b + t, 5'b0, 5'h1f, "all_running");
      for (int t = 30; t <= 430; t++) push(b + t, 5'b0, 5'b0, "reset_abort");
      pulse(5'h1f, 5'b0);
      wait_until(b + 29);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      tick();
      tick();
      tick();
      reset_n = 1'b1;
      wait_until(b + 430);

      tick();
      tick();
      n_checks++;
      if (sb_q.size() != 0)
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
